// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, output port codes, input port FSM
// states and the XY dimension-order routing function.
package noc_pkg;

  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  localparam logic [2:0] PORT_LOCAL = 3'd0;
  localparam logic [2:0] PORT_NORTH = 3'd1;
  localparam logic [2:0] PORT_EAST  = 3'd2;
  localparam logic [2:0] PORT_SOUTH = 3'd3;
  localparam logic [2:0] PORT_WEST  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RES = 3'd2,
    ST_FWD      = 3'd3,
    ST_RELIEVE  = 3'd4
  } port_state_t;

  function automatic logic opens_packet(input logic [1:0] flit_type);
    return (flit_type == FLIT_HEAD) || (flit_type == FLIT_SINGLE);
  endfunction

  function automatic logic closes_packet(input logic [1:0] flit_type);
    return (flit_type == FLIT_TAIL) || (flit_type == FLIT_SINGLE);
  endfunction

  // X is resolved completely before Y, which keeps the mesh deadlock-free.
  function automatic logic [2:0] xy_route(input int dest_x, input int dest_y,
                                          input int cur_x, input int cur_y);
    logic [2:0] port;
    if (dest_x > cur_x)      port = PORT_EAST;
    else if (dest_x < cur_x) port = PORT_WEST;
    else if (dest_y > cur_y) port = PORT_SOUTH;
    else if (dest_y < cur_y) port = PORT_NORTH;
    else                     port = PORT_LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit buffer with registered occupancy count; the head entry is
// presented combinationally on rd_data.
module noc_flit_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      if (do_wr && !do_rd)      count <= count + 1'b1;
      else if (!do_wr && do_rd) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/noc_input_port_ctrl.sv
// Router input port: buffers flits, computes the XY route of each head flit,
// reserves a crossbar path, forwards the packet and relieves the path.
module noc_input_port_ctrl
  import noc_pkg::*;
#(
  parameter int N             = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int REQUEST_WIDTH = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int X_POS         = 0,
  parameter int Y_POS         = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     route_req_valid,
  output logic [REQUEST_WIDTH-1:0] route_req,
  input  logic                     route_status,
  input  logic                     port_reserved,
  output logic                     route_relieve,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int CW = $clog2(N);

  logic [DATA_WIDTH-1:0]      head_flit;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                       fifo_wr;
  logic                       fifo_rd;

  logic [1:0]                 head_type;
  logic [CW-1:0]              dest_x;
  logic [CW-1:0]              dest_y;
  logic [REQUEST_WIDTH-1:0]   head_route;

  port_state_t                state;
  port_state_t                state_next;
  logic [REQUEST_WIDTH-1:0]   req_q;
  logic [REQUEST_WIDTH-1:0]   req_next;
  logic                       fwd_has_flit;

  assign in_ready = !rst && !fifo_full;
  assign fifo_wr  = in_valid && in_ready;

  noc_flit_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (in_data),
    .wr_en   (fifo_wr),
    .rd_en   (fifo_rd),
    .rd_data (head_flit),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign head_type  = head_flit[DATA_WIDTH-1 -: 2];
  assign dest_x     = head_flit[2*CW-1 -: CW];
  assign dest_y     = head_flit[CW-1:0];
  assign head_route = REQUEST_WIDTH'(xy_route(int'(dest_x), int'(dest_y), X_POS, Y_POS));

  // route_req is only reloaded in IDLE, so it stays put through RELIEVE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      req_q <= '0;
    end else begin
      state <= state_next;
      req_q <= req_next;
    end
  end

  assign fwd_has_flit = (fifo_count != '0);

  always_comb begin
    state_next      = state;
    req_next        = req_q;
    fifo_rd         = 1'b0;
    route_req_valid = 1'b0;
    route_relieve   = 1'b0;
    out_valid       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (opens_packet(head_type)) begin
            req_next   = head_route;
            state_next = ST_REQ;
          end else begin
            fifo_rd = 1'b1;
          end
        end
      end
      ST_REQ: begin
        route_req_valid = 1'b1;
        if (route_status) state_next = ST_WAIT_RES;
      end
      ST_WAIT_RES: begin
        if (port_reserved) state_next = ST_FWD;
      end
      ST_FWD: begin
        out_valid = fwd_has_flit;
        if (fwd_has_flit && out_ready) begin
          fifo_rd = 1'b1;
          if (closes_packet(head_type)) state_next = ST_RELIEVE;
        end
      end
      ST_RELIEVE: begin
        route_relieve = 1'b1;
        state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign route_req = req_q;
  assign out_data  = (state == ST_FWD && !fifo_empty) ? head_flit : '0;

endmodule
